pcie_rst_seq: RTL and testbench

PCIE_RST_SEQ -- requirements
Module: pcie_rst_seq

---
 rtl/pcie_rst_seq_pkg.sv | 42 ++++
 rtl/pcie_rst_seq_delay_cnt.sv | 36 +++
 rtl/pcie_rst_seq.sv | 165 ++++++++++++++++
 tb/tb_pcie_rst_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// pcie_rst_seq_pkg
// Shared constants for the PCIe link reset sequencer: sequencer state
// encoding, CSR register offsets relative to the block base address, CTRL
// bit positions, and a helper that maps a sequencer state to the set of
// links it has already released.
// -----------------------------------------------------------------------------
package pcie_rst_seq_pkg;

   typedef enum logic [2:0] {
      ST_HOLD   = 3'd0,
      ST_WAIT_A = 3'd1,
      ST_WAIT_B = 3'd2,
      ST_WAIT_C = 3'd3,
      ST_DONE   = 3'd4
   } seq_state_t;

   // Register offsets from BASE_ADDR
   localparam logic [4:0] OFS_CTRL  = 5'd0;
   localparam logic [4:0] OFS_DELAY = 5'd1;

   // CTRL bit positions
   localparam int CTRL_SW_RST_LSB = 0;
   localparam int CTRL_SW_RST_MSB = 2;
   localparam int CTRL_RESTART    = 6;
   localparam int CTRL_DONE       = 7;

   // Links released by the sequencer once it has reached a given state.
   // Bit 0 = link A, bit 1 = link B, bit 2 = link C.
   function automatic logic [2:0] released_links(input seq_state_t st);
      logic [2:0] rel;
      rel = 3'b000;
      case (st)
         ST_WAIT_B: rel = 3'b001;
         ST_WAIT_C: rel = 3'b011;
         ST_DONE:   rel = 3'b111;
         default:   rel = 3'b000;
      endcase
      return rel;
   endfunction

endpackage

// File: rtl/pcie_rst_seq_delay_cnt.sv
// -----------------------------------------------------------------------------
// delay_cnt
// 8-bit down counter pacing the link releases.
// Ports:
//   clk, rst_n  : system clock, synchronous active-low reset (count -> 0)
//   load        : load load_val (has priority over dec)
//   load_val    : value to load
//   dec         : decrement request (caller gates this with ce)
//   cnt         : current count
//   zero        : count is 0
// -----------------------------------------------------------------------------
module delay_cnt (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       dec,
   output logic [7:0] cnt,
   output logic       zero
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= 8'h00;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && !zero) begin
         // Holding at zero keeps the count from wrapping if a decrement
         // ever arrives on the cycle the owner is about to reload.
         cnt <= cnt - 8'd1;
      end
   end

   assign zero = (cnt == 8'h00);

endmodule

// File: rtl/pcie_rst_seq.sv
// -----------------------------------------------------------------------------
// pcie_rst_seq
// Releases three PCIe link resets (A, then B, then C) after a programmable
// number of ce ticks each, with software override and restart via two CSRs.
// Ports:
//   clk, rst_n : system clock, synchronous active-low reset
//   ce         : one-cycle tick that paces the release delays
//   csr_a      : CSR address (block occupies BASE_ADDR and BASE_ADDR+1)
//   csr_di     : CSR write data
//   csr_we     : CSR write strobe
//   csr_do     : CSR read data, 0 when this block is not addressed
//   pcie_rst   : registered active-high link resets, bit0=A bit1=B bit2=C
//   seq_done   : high while the sequencer is in its DONE state
// Registers:
//   BASE+0 CTRL  : [2:0] SW_RST rw, [6] RESTART wo, [7] DONE ro
//   BASE+1 DELAY : release delay in ce ticks
// -----------------------------------------------------------------------------
module pcie_rst_seq
   import pcie_rst_seq_pkg::*;
#(
   parameter logic [4:0] BASE_ADDR = 5'h0,
   parameter logic [7:0] DFL_DELAY = 8'h20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ce,
   input  logic [4:0] csr_a,
   input  logic [7:0] csr_di,
   input  logic       csr_we,
   output logic [7:0] csr_do,
   output logic [2:0] pcie_rst,
   output logic       seq_done
);

   localparam logic [4:0] ADDR_CTRL  = BASE_ADDR + OFS_CTRL;
   localparam logic [4:0] ADDR_DELAY = BASE_ADDR + OFS_DELAY;

   seq_state_t state_q;
   seq_state_t state_d;

   logic [2:0] sw_rst_q;
   logic [2:0] sw_rst_d;
   logic [7:0] delay_q;

   logic       sel_ctrl;
   logic       sel_delay;
   logic       wr_ctrl;
   logic       wr_delay;
   logic       restart;

   logic       cnt_load;
   logic       cnt_dec;
   logic [7:0] cnt;
   logic       cnt_zero;

   // ---------------------------------------------------------------- decode
   assign sel_ctrl  = (csr_a == ADDR_CTRL);
   assign sel_delay = (csr_a == ADDR_DELAY);
   assign wr_ctrl   = csr_we && sel_ctrl;
   assign wr_delay  = csr_we && sel_delay;
   assign restart   = wr_ctrl && csr_di[CTRL_RESTART];

   assign sw_rst_d  = wr_ctrl ? csr_di[CTRL_SW_RST_MSB:CTRL_SW_RST_LSB] : sw_rst_q;

   // --------------------------------------------------------- delay counter
   delay_cnt u_delay_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (delay_q),
      .dec      (cnt_dec),
      .cnt      (cnt),
      .zero     (cnt_zero)
   );

   // ------------------------------------------------------ sequencer state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_HOLD;
      end else begin
         state_q <= state_d;
      end
   end

   // Restart beats a release landing on the same cycle. The counter reload
   // always uses the DELAY value already in the register, so a DELAY write
   // in flight only affects a later reload.
   always_comb begin
      state_d  = state_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      if (restart) begin
         state_d = ST_HOLD;
      end else begin
         case (state_q)
            ST_HOLD: begin
               state_d  = ST_WAIT_A;
               cnt_load = 1'b1;
            end
            ST_WAIT_A: begin
               if (cnt_zero) begin
                  state_d  = ST_WAIT_B;
                  cnt_load = 1'b1;
               end else begin
                  cnt_dec = ce;
               end
            end
            ST_WAIT_B: begin
               if (cnt_zero) begin
                  state_d  = ST_WAIT_C;
                  cnt_load = 1'b1;
               end else begin
                  cnt_dec = ce;
               end
            end
            ST_WAIT_C: begin
               if (cnt_zero) begin
                  state_d  = ST_DONE;
                  cnt_load = 1'b1;
               end else begin
                  cnt_dec = ce;
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = ST_HOLD;
            end
         endcase
      end
   end

   // ------------------------------------------------- CSRs and link outputs
   // pcie_rst is computed from the next state and next SW_RST so it changes
   // on the same edge as the state/CTRL register it reflects; seq_done then
   // rises together with the last release.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sw_rst_q <= 3'b000;
         delay_q  <= DFL_DELAY;
         pcie_rst <= 3'b111;
      end else begin
         sw_rst_q <= sw_rst_d;
         if (wr_delay) begin
            delay_q <= csr_di;
         end
         pcie_rst <= ~released_links(state_d) | sw_rst_d;
      end
   end

   assign seq_done = (state_q == ST_DONE);

   // ------------------------------------------------------------- readback
   always_comb begin
      csr_do = 8'h00;
      if (sel_ctrl) begin
         csr_do[CTRL_SW_RST_MSB:CTRL_SW_RST_LSB] = sw_rst_q;
         csr_do[CTRL_DONE]                       = seq_done;
      end else if (sel_delay) begin
         csr_do = delay_q;
      end
   end

endmodule

// File: tb/tb_pcie_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_pcie_rst_seq
// Self-checking bench for pcie_rst_seq. A behavioural model tracks how many
// links have been released, whether the sequencer is holding, and how many
// ce ticks remain; every cycle the DUT outputs are compared against it.
// Directed scenarios cover power-up ordering, zero delay, software reset,
// restart, in-flight DELAY writes, unmapped reads and mid-sequence reset,
// followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_pcie_rst_seq;

   localparam logic [4:0] BASE = 5'h0C;
   localparam logic [7:0] DFL  = 8'h20;

   logic       clk;
   logic       rst_n;
   logic       ce;
   logic [4:0] csr_a;
   logic [7:0] csr_di;
   logic       csr_we;
   logic [7:0] csr_do;
   logic [2:0] pcie_rst;
   logic       seq_done;

   pcie_rst_seq #(
      .BASE_ADDR (BASE),
      .DFL_DELAY (DFL)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ce       (ce),
      .csr_a    (csr_a),
      .csr_di   (csr_di),
      .csr_we   (csr_we),
      .csr_do   (csr_do),
      .pcie_rst (pcie_rst),
      .seq_done (seq_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   bit         m_hold   = 1'b1;
   int         m_nrel   = 0;
   int         m_remain = 0;
   logic [2:0] m_sw     = 3'b000;
   logic [7:0] m_delay  = DFL;

   logic [2:0] obs_rst;
   logic       obs_done;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic m_done();
      return (m_nrel == 3) && !m_hold;
   endfunction

   function automatic logic [2:0] exp_rst();
      logic [2:0] e;
      for (int i = 0; i < 3; i++) e[i] = (i >= m_nrel) || m_sw[i];
      return e;
   endfunction

   function automatic logic [7:0] exp_do(input logic [4:0] a);
      if (a == BASE)              return {m_done(), 4'b0000, m_sw};
      else if (a == BASE + 5'd1)  return m_delay;
      else                        return 8'h00;
   endfunction

   task automatic model_step(input bit r, input bit c, input bit we,
                             input logic [4:0] a, input logic [7:0] d);
      bit         rs;
      logic [2:0] sw_n;
      logic [7:0] dl_n;
      if (!r) begin
         m_hold = 1'b1; m_nrel = 0; m_remain = 0; m_sw = 3'b000; m_delay = DFL;
         return;
      end
      rs   = we && (a == BASE) && d[6];
      sw_n = (we && a == BASE) ? d[2:0] : m_sw;
      dl_n = (we && a == BASE + 5'd1) ? d : m_delay;
      if (rs) begin
         m_hold = 1'b1; m_nrel = 0;
      end else if (m_hold) begin
         m_hold = 1'b0; m_remain = int'(m_delay);
      end else if (m_nrel < 3) begin
         if (m_remain == 0) begin
            m_nrel++; m_remain = int'(m_delay);
         end else if (c) begin
            m_remain--;
         end
      end
      m_sw    = sw_n;
      m_delay = dl_n;
   endtask

   // One clock: check the current outputs, then drive inputs for this cycle.
   task automatic cycle(input bit r, input bit c, input bit we,
                        input logic [4:0] a, input logic [7:0] d);
      @(negedge clk);
      chk("pcie_rst", {29'd0, pcie_rst}, {29'd0, exp_rst()});
      chk("seq_done", {31'd0, seq_done}, {31'd0, m_done()});
      chk("csr_do",   {24'd0, csr_do},   {24'd0, exp_do(csr_a)});
      obs_rst  = pcie_rst;
      obs_done = seq_done;
      rst_n = r; ce = c; csr_we = we; csr_a = a; csr_di = d;
      model_step(r, c, we, a, d);
   endtask

   task automatic wr(input logic [4:0] a, input logic [7:0] d);
      cycle(1'b1, 1'b0, 1'b1, a, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 5'($urandom_range(0, 31)), 8'h00);
   endtask

   task automatic wait_rst(input logic [2:0] v, input string tag);
      for (int i = 0; i < 600; i++) begin
         cycle(1'b1, 1'b1, 1'b0, BASE, 8'h00);
         if (obs_rst == v) break;
      end
      chk(tag, {29'd0, obs_rst}, {29'd0, v});
   endtask

   initial begin
      logic [2:0] prev;
      logic [2:0] steps [3];
      int         idx;
      int         ce_cnt;
      bit         c;

      rst_n = 1'b0; ce = 1'b0; csr_a = BASE; csr_di = 8'h00; csr_we = 1'b0;

      // Reset overrides ce, writes and restart
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, BASE, 8'h47);
      cycle(1'b0, 1'b1, 1'b1, BASE + 5'd1, 8'h05);

      // Power-up ordering with default DELAY and ce every 4th cycle
      steps[0] = 3'b110; steps[1] = 3'b100; steps[2] = 3'b000;
      prev = 3'b111; idx = 0; ce_cnt = 0;
      for (int k = 0; k < 2000 && idx < 3; k++) begin
         c = ((k % 4) == 3);
         cycle(1'b1, c, 1'b0, BASE + 5'd1, 8'h00);
         if (obs_rst != prev) begin
            chk("pwr_step", {29'd0, obs_rst}, {29'd0, steps[idx]});
            chk("pwr_gap", ce_cnt, 32);
            if (idx == 2) chk("pwr_done", {31'd0, obs_done}, 32'd1);
            idx++;
            prev = obs_rst;
            ce_cnt = 0;
         end
         ce_cnt += int'(c);
      end
      chk("pwr_final", {29'd0, obs_rst}, 32'd0);

      // DELAY=0 then RESTART: seq_done 5 cycles after the restart write
      wr(BASE + 5'd1, 8'h00);
      wr(BASE, 8'h40);
      for (int i = 1; i <= 5; i++) begin
         cycle(1'b1, 1'b0, 1'b0, BASE, 8'h00);
         if (i == 1) chk("d0_hold", {29'd0, obs_rst}, 32'h7);
         if (i == 4) chk("d0_done4", {31'd0, obs_done}, 32'd0);
         if (i == 5) chk("d0_done5", {31'd0, obs_done}, 32'd1);
      end

      // SW_RST while done
      wr(BASE, 8'h02);
      cycle(1'b1, 1'b1, 1'b0, BASE, 8'h00);
      chk("sw_rst_on", {29'd0, obs_rst}, 32'h2);
      wr(BASE, 8'h00);
      cycle(1'b1, 1'b1, 1'b0, BASE, 8'h00);
      chk("sw_rst_off", {29'd0, obs_rst}, 32'h0);
      chk("sw_done", {31'd0, obs_done}, 32'd1);

      // Restart in WAIT_B
      wr(BASE + 5'd1, 8'h04);
      wr(BASE, 8'h40);
      wait_rst(3'b110, "reach_wait_b");
      idle(2);
      wr(BASE, 8'h40);
      cycle(1'b1, 1'b1, 1'b0, BASE, 8'h00);
      chk("restart_111", {29'd0, obs_rst}, 32'h7);
      idle(3);
      wait_rst(3'b110, "rerun_a");
      wait_rst(3'b000, "rerun_done");

      // DELAY write while WAIT_A is counting
      wr(BASE + 5'd1, 8'd20);
      wr(BASE, 8'h40);
      cycle(1'b1, 1'b0, 1'b0, BASE, 8'h00);
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, BASE + 5'd1, 8'h00);
      wr(BASE + 5'd1, 8'd3);
      for (int i = 0; i < 120; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, BASE, 8'h00);

      // Unmapped reads
      cycle(1'b1, 1'b0, 1'b0, 5'h1F, 8'h00);
      cycle(1'b1, 1'b0, 1'b0, BASE + 5'd2, 8'h00);
      cycle(1'b1, 1'b0, 1'b0, BASE - 5'd1, 8'h00);

      // Reset during WAIT_C
      wr(BASE + 5'd1, 8'h08);
      wr(BASE, 8'h41);
      wait_rst(3'b101, "reach_wait_c");
      cycle(1'b0, 1'b1, 1'b1, BASE + 5'd1, 8'h11);
      cycle(1'b1, 1'b0, 1'b0, BASE + 5'd1, 8'h00);
      chk("rst_wait_c", {29'd0, obs_rst}, 32'h7);
      idle(4);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bit         r, w;
         logic [4:0] a;
         logic [7:0] d;
         r = ($urandom_range(0, 499) != 0);
         w = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 3))
            0, 1:    a = BASE;
            2:       a = BASE + 5'd1;
            default: a = 5'($urandom_range(0, 31));
         endcase
         d = 8'($urandom_range(0, 255));
         if (w && a == BASE && $urandom_range(0, 5) != 0) d[6] = 1'b0;
         if (w && a == BASE + 5'd1 && $urandom_range(0, 7) != 0) d = 8'($urandom_range(0, 6));
         cycle(r, 1'($urandom_range(0, 1)), w, a, d);
      end
      cycle(1'b1, 1'b0, 1'b0, BASE, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
